// File: rtl/scalar_mult_pkg.sv
// Shared widths and FSM encoding for the scalar-multiplication core scheduler.
package scalar_mult_pkg;

    localparam int FIELD_W = 255;
    localparam int CYC_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

endpackage

// File: rtl/scalar_mult_scheduler_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(N)) begin
                w_sum = w_sum - (ID_W + 1)'(N);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/scalar_mult_scheduler.sv
// Time-shares one scalar-multiplication core among NUM_REQ requesters with round-robin
// grants, per-job operand latching, core reset sequencing and a timeout watchdog.
module scalar_mult_scheduler
    import scalar_mult_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int CORE_RST_CYC = 4,
    parameter  int TIMEOUT_CYC  = 2**20,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FIELD_W-1:0] req_k,
    input  logic [NUM_REQ*FIELD_W-1:0] req_x_p,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [FIELD_W-1:0]         resp_x_q,
    output logic                       resp_err,
    output logic [CYC_W-1:0]           resp_cycles,
    output logic [FIELD_W-1:0]         core_k,
    output logic [FIELD_W-1:0]         core_x_p,
    output logic                       core_rst,
    input  logic [FIELD_W-1:0]         core_x_q,
    input  logic                       core_done,
    output logic                       busy
);

    localparam logic [CYC_W-1:0] LOAD_LAST = CYC_W'(CORE_RST_CYC - 1);
    localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(TIMEOUT_CYC - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [ID_W-1:0]      r_ptr;
    logic [CYC_W-1:0]     r_cnt;
    logic [FIELD_W-1:0]   r_core_k;
    logic [FIELD_W-1:0]   r_core_x_p;
    logic [FIELD_W-1:0]   r_resp_x_q;
    logic [ID_W-1:0]      r_resp_id;
    logic [CYC_W-1:0]     r_resp_cycles;
    logic                 r_resp_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_any;
    logic                 w_timeout;
    logic [FIELD_W-1:0]   w_k_arr   [NUM_REQ];
    logic [FIELD_W-1:0]   w_x_p_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_k_arr[gi]   = req_k[gi*FIELD_W +: FIELD_W];
        assign w_x_p_arr[gi] = req_x_p[gi*FIELD_W +: FIELD_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id),
        .any      (w_any)
    );

    assign w_timeout = (r_cnt == TO_LAST);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_any)                    w_next_state = LOAD;
            LOAD:    if (r_cnt == LOAD_LAST)       w_next_state = RUN;
            RUN:     if (core_done || w_timeout)   w_next_state = RESP;
            RESP:    if (resp_ready)               w_next_state = IDLE;
            default:                               w_next_state = IDLE;
        endcase
    end

    // The core stays in reset everywhere except RUN, so it is parked between jobs.
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        core_rst   = 1'b1;
        busy       = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) req_ready = w_grant;
            end
            RUN:     core_rst   = 1'b0;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_core_k      <= '0;
            r_core_x_p    <= '0;
            r_resp_x_q    <= '0;
            r_resp_id     <= '0;
            r_resp_cycles <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_any) begin
                    r_core_k   <= w_k_arr[w_grant_id];
                    r_core_x_p <= w_x_p_arr[w_grant_id];
                    r_resp_id  <= w_grant_id;
                    r_ptr      <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
                    r_cnt      <= '0;
                end
                LOAD: r_cnt <= (r_cnt == LOAD_LAST) ? '0 : r_cnt + CYC_W'(1);
                RUN: begin
                    if (core_done) begin
                        r_resp_x_q    <= core_x_q;
                        r_resp_cycles <= r_cnt;
                        r_resp_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_x_q    <= '0;
                        r_resp_cycles <= r_cnt;
                        r_resp_err    <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CYC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_k      = r_core_k;
    assign core_x_p    = r_core_x_p;
    assign resp_x_q    = r_resp_x_q;
    assign resp_id     = r_resp_id;
    assign resp_cycles = r_resp_cycles;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_scalar_mult_scheduler.sv
// Randomized self-checking bench for scalar_mult_scheduler with an xor core stub.
module tb_scalar_mult_scheduler;

    localparam int N = 4;
    localparam int C = 4;
    localparam int T = 64;
    localparam int W = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_k;
    logic [N*W-1:0]   req_x_p;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_x_q;
    logic             resp_err;
    logic [31:0]      resp_cycles;
    logic [W-1:0]     core_k;
    logic [W-1:0]     core_x_p;
    logic             core_rst;
    logic [W-1:0]     core_x_q;
    logic             core_done;
    logic             busy;

    int checks = 0;
    int fails  = 0;
    int m_ptr  = 0;
    int last_wait;
    int stub_d = 0;
    bit stub_hang = 1'b0;
    int stub_cnt = 0;
    logic [W-1:0] op_k [N];
    logic [W-1:0] op_x [N];

    always #5 clk = ~clk;

    scalar_mult_scheduler #(.NUM_REQ(N), .CORE_RST_CYC(C), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_k(req_k), .req_x_p(req_x_p), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_x_q(resp_x_q), .resp_err(resp_err), .resp_cycles(resp_cycles),
        .core_k(core_k), .core_x_p(core_x_p), .core_rst(core_rst), .core_x_q(core_x_q),
        .core_done(core_done), .busy(busy)
    );

    // Core stub: done D cycles after reset release, result = k ^ x_p.
    always @(posedge clk) begin
        if (core_rst) stub_cnt <= 0;
        else if (stub_cnt < 1000000) stub_cnt <= stub_cnt + 1;
    end
    assign core_done = !stub_hang && (stub_cnt >= stub_d);
    assign core_x_q  = core_k ^ core_x_p;

    function automatic logic [W-1:0] rand255();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v[W-1:0];
    endfunction

    function automatic int model_grant(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_k[i*W +: W]   = op_k[i];
            req_x_p[i*W +: W] = op_x[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input logic [N-1:0] mask, input int d, input bit hang,
                           input int hold, input bit rnd);
        int n, cyc, hi, exp_g, exp_lat;
        logic [N-1:0] exp_rr;
        logic [W-1:0] exp_x, s_x;
        logic [1:0]   s_id;
        logic [31:0]  s_c;
        logic         s_e;
        bit           stable;
        if (rnd) for (int i = 0; i < N; i++) begin op_k[i] = rand255(); op_x[i] = rand255(); end
        drive_ops();
        stub_d = d; stub_hang = hang; resp_ready = 1'b0;
        req_valid = mask;
        exp_g  = model_grant(mask);
        exp_rr = N'(1) << exp_g;
        #1;
        n = 0;
        while (req_ready === '0 && n < 20) begin step(); n++; end
        last_wait = n;
        checks++;
        if (req_ready !== exp_rr) begin
            fails++;
            $display("FAIL grant: req_ready=%b expected=%b", req_ready, exp_rr);
            return;
        end
        exp_x = op_k[exp_g] ^ op_x[exp_g];
        m_ptr = (exp_g + 1) % N;
        step(); cyc = 1;
        op_k[exp_g] = rand255(); op_x[exp_g] = rand255(); drive_ops();
        checks++;
        if (req_ready !== '0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL load_state: req_ready=%b core_rst=%b expected 0 and 1", req_ready, core_rst);
        end
        hi = 1;
        while (core_rst === 1'b1 && hi < 50) begin step(); cyc++; if (core_rst === 1'b1) hi++; end
        checks++;
        if (hi !== C) begin fails++; $display("FAIL core_rst_len: got=%0d expected=%0d", hi, C); end
        n = 0;
        while (resp_valid !== 1'b1 && n < T + 50) begin step(); cyc++; n++; end
        exp_lat = C + (hang ? T - 1 : d) + 2;
        checks++;
        if (cyc !== exp_lat) begin fails++; $display("FAIL latency: got=%0d expected=%0d", cyc, exp_lat); end
        checks++;
        if (resp_id !== 2'(exp_g)) begin fails++; $display("FAIL resp_id: got=%0d expected=%0d", resp_id, exp_g); end
        checks++;
        if (resp_err !== hang) begin fails++; $display("FAIL resp_err: got=%b expected=%b", resp_err, hang); end
        checks++;
        if (resp_x_q !== (hang ? '0 : exp_x)) begin
            fails++;
            $display("FAIL resp_x_q: got=%h expected=%h", resp_x_q, hang ? '0 : exp_x);
        end
        if (!hang) begin
            checks++;
            if (resp_cycles !== 32'(d)) begin fails++; $display("FAIL resp_cycles: got=%0d expected=%0d", resp_cycles, d); end
        end
        if (hold > 0) begin
            stable = 1'b1;
            s_x = resp_x_q; s_id = resp_id; s_c = resp_cycles; s_e = resp_err;
            for (int k = 0; k < hold; k++) begin
                step();
                if (resp_valid !== 1'b1 || resp_x_q !== s_x || resp_id !== s_id || resp_cycles !== s_c ||
                    resp_err !== s_e || req_ready !== '0 || busy !== 1'b1) stable = 1'b0;
            end
            checks++;
            if (!stable) begin fails++; $display("FAIL backpressure: resp_* or req_ready changed, stable=%b expected=1", stable); end
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL handshake: resp_valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_ready = 1'b0; req_valid = '1;
        for (int i = 0; i < N; i++) begin op_k[i] = rand255(); op_x[i] = rand255(); end
        drive_ops();
        repeat (3) step();
        checks++;
        if (req_ready !== '0 || core_rst !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: req_ready=%b core_rst=%b busy=%b resp_valid=%b expected 0 1 0 0",
                     req_ready, core_rst, busy, resp_valid);
        end
        checks++;
        if (resp_x_q !== '0 || resp_err !== 1'b0 || resp_id !== '0 || resp_cycles !== '0 ||
            core_k !== '0 || core_x_p !== '0) begin
            fails++;
            $display("FAIL reset_data: x_q=%h err=%b id=%0d cycles=%0d core_k=%h expected all 0",
                     resp_x_q, resp_err, resp_id, resp_cycles, core_k);
        end
        req_valid = '0;
        rst = 1'b0;
        m_ptr = 0;
        step();
    endtask

    task automatic test_single();
        op_k[0] = W'(5); op_x[0] = W'(3);
        run_one(4'b0001, 10, 1'b0, 0, 1'b0);
        req_valid = '0;
    endtask

    task automatic test_fairness();
        for (int j = 0; j < 8; j++) begin
            run_one(4'b1111, int'($urandom_range(0, 12)), 1'b0, 0, 1'b1);
            if (j > 0) begin
                checks++;
                if (last_wait !== 0) begin fails++; $display("FAIL back_to_back: wait=%0d expected=0", last_wait); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        run_one(4'b1011, 7, 1'b0, 20, 1'b1);
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            run_one(N'($urandom_range(1, 15)), int'($urandom_range(0, 30)), 1'b0, int'($urandom_range(0, 3)), 1'b1);
        end
        req_valid = '0;
    endtask

    task automatic test_boundary();
        run_one(4'b0110, 0, 1'b0, 0, 1'b1);
        run_one(4'b1001, T - 1, 1'b0, 0, 1'b1);
        req_valid = '0;
    endtask

    task automatic test_timeout();
        run_one(4'b0100, 0, 1'b1, 0, 1'b1);
        run_one(4'b0100, 9, 1'b0, 0, 1'b1);
        req_valid = '0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit seen;
        stub_hang = 1'b0; stub_d = 30;
        req_valid = 4'b0100;
        #1;
        n = 0;
        while (req_ready === '0 && n < 20) begin step(); n++; end
        checks++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL mid_grant: req_ready=%b expected=0100", req_ready); end
        m_ptr = 3;
        step();
        req_valid = '0;
        repeat (C + 3) step();
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_run_state: core_rst=%b busy=%b expected 0 1", core_rst, busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || core_k !== '0 || resp_id !== '0) begin
            fails++;
            $display("FAIL mid_reset: core_rst=%b busy=%b resp_valid=%b resp_id=%0d expected 1 0 0 0",
                     core_rst, busy, resp_valid, resp_id);
        end
        rst = 1'b0;
        m_ptr = 0;
        seen = 1'b0;
        repeat (40) begin step(); if (resp_valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen) begin fails++; $display("FAIL mid_no_resp: resp_valid seen=%b expected=0", seen); end
        run_one(4'b1111, 5, 1'b0, 0, 1'b1);
        req_valid = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0; req_k = '0; req_x_p = '0;
        #2;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_random();
        test_boundary();
        test_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
